// File: rtl/tail_light_pkg.sv
// Shared tail-light state codes and lamp pattern constants.
// Used by the next-state logic and by tail_light_seq.
package tail_light_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;
    localparam int unsigned PHASE_W = 2;

    localparam logic [STATE_W-1:0] IDLE       = 3'b000;
    localparam logic [STATE_W-1:0] HAZARDS    = 3'b001;
    localparam logic [STATE_W-1:0] TURN_LEFT  = 3'b010;
    localparam logic [STATE_W-1:0] TURN_RIGHT = 3'b011;

    localparam logic [LAMP_W-1:0] LAMPS_ON  = 3'b111;
    localparam logic [LAMP_W-1:0] LAMPS_OFF = 3'b000;

    // Turn sweep indexed by phase: inner lamp first, then all dark
    localparam logic [3:0][LAMP_W-1:0] TURN_SWEEP = {3'b000, 3'b111, 3'b011, 3'b001};

    typedef struct packed {
        logic [LAMP_W-1:0] left;
        logic [LAMP_W-1:0] right;
    } lampPair_t;

    // Undefined codes (MSB set) are treated as IDLE
    function automatic logic [STATE_W-1:0] decodeState(input logic [STATE_W-1:0] code);
        return code[STATE_W-1] ? IDLE : code;
    endfunction

endpackage

// File: rtl/tail_light_seq_tick_gen.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 and pulses step_c on the last count.
module tick_gen #(
    parameter  int unsigned TICK_DIV = 12_500_000,
    localparam int unsigned CNT_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic step_c
);

    logic [CNT_W-1:0] cnt;

    assign step_c = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (step_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Tail lamp sequencer: turn sweep, hazard blink and idle patterns from the state code.
// Optional brake input enabled by defining TAIL_LIGHT_SEQ_BRAKE_EN.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] CurrentState,
`ifdef TAIL_LIGHT_SEQ_BRAKE_EN
    input  logic               brake,
`endif
    output logic [LAMP_W-1:0]  L_lamps,
    output logic [LAMP_W-1:0]  R_lamps,
    output logic               bad_state
);

    logic [STATE_W-1:0] stateQ;
    logic [STATE_W-1:0] decoded;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phaseNext;
    logic               stateChange;
    logic               step;
    logic               brakeOn;
    lampPair_t          lampsNext;

`ifdef TAIL_LIGHT_SEQ_BRAKE_EN
    assign brakeOn = brake;
`else
    assign brakeOn = 1'b0;
`endif

    // Brake lights the side not used for signalling; hazards override brake
    function automatic lampPair_t selectPattern(
        input logic [STATE_W-1:0] st,
        input logic [PHASE_W-1:0] ph,
        input logic               brk
    );
        lampPair_t p;
        p.left  = LAMPS_OFF;
        p.right = LAMPS_OFF;
        case (st)
            TURN_LEFT: begin
                p.left = TURN_SWEEP[ph];
                if (brk) p.right = LAMPS_ON;
            end
            TURN_RIGHT: begin
                p.right = TURN_SWEEP[ph];
                if (brk) p.left = LAMPS_ON;
            end
            HAZARDS: begin
                if (!ph[0]) begin
                    p.left  = LAMPS_ON;
                    p.right = LAMPS_ON;
                end
            end
            default: begin
                if (brk) begin
                    p.left  = LAMPS_ON;
                    p.right = LAMPS_ON;
                end
            end
        endcase
        return p;
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (stateChange),
        .step_c (step)
    );

    // A state change restarts the sequence and takes priority over a step
    always_comb begin
        decoded     = decodeState(CurrentState);
        stateChange = (decoded != stateQ);
        phaseNext   = phase;
        if (stateChange) begin
            phaseNext = '0;
        end else if (step) begin
            phaseNext = phase + PHASE_W'(1);
        end
        lampsNext = selectPattern(decoded, phaseNext, brakeOn);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            phase     <= '0;
            L_lamps   <= LAMPS_OFF;
            R_lamps   <= LAMPS_OFF;
            bad_state <= 1'b0;
        end else begin
            stateQ    <= decoded;
            phase     <= phaseNext;
            L_lamps   <= lampsNext.left;
            R_lamps   <= lampsNext.right;
            bad_state <= CurrentState[STATE_W-1];
        end
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: directed vector table plus randomized run against a time-based model.
module tb_tail_light_seq;

    localparam int unsigned TICK_DIV = 4;
`ifdef TAIL_LIGHT_SEQ_BRAKE_EN
    localparam bit BRAKE_EN = 1'b1;
`else
    localparam bit BRAKE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] CurrentState = 3'b000;
    logic       brake = 1'b0;
    logic [2:0] L_lamps;
    logic [2:0] R_lamps;
    logic       bad_state;

    tail_light_seq #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .CurrentState (CurrentState),
`ifdef TAIL_LIGHT_SEQ_BRAKE_EN
        .brake        (brake),
`endif
        .L_lamps      (L_lamps),
        .R_lamps      (R_lamps),
        .bad_state    (bad_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] cs;
        logic       brk;
        logic [2:0] eL;
        logic [2:0] eR;
        logic       eBad;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Model: state plus cycles elapsed since the state was entered
    int         mState = 0;
    int         mAge = 0;
    logic [2:0] mL = 3'b000;
    logic [2:0] mR = 3'b000;
    logic       mBad = 1'b0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {left, right}; phase derived from elapsed time
    function automatic logic [5:0] refLamps(input int st, input int age, input bit brk);
        int         ph;
        logic [2:0] sweep;
        logic [2:0] on;
        ph    = (age / TICK_DIV) % 4;
        sweep = (ph < 3) ? 3'((1 << (ph + 1)) - 1) : 3'b000;
        on    = (brk && BRAKE_EN) ? 3'b111 : 3'b000;
        case (st)
            1:       return (ph % 2 == 0) ? 6'o77 : 6'o00;
            2:       return {sweep, on};
            3:       return {on, sweep};
            default: return {on, on};
        endcase
    endfunction

    task automatic modelEdge(input logic rst, input logic [2:0] cs, input logic brk);
        int dec;
        if (!rst) begin
            mState = 0;
            mAge   = 0;
            mL     = 3'b000;
            mR     = 3'b000;
            mBad   = 1'b0;
        end else begin
            dec = (cs >= 3'd4) ? 0 : int'(cs);
            if (dec != mState) begin
                mState = dec;
                mAge   = 0;
            end else begin
                mAge++;
            end
            {mL, mR} = refLamps(mState, mAge, brk);
            mBad     = cs[2];
        end
    endtask

    task automatic cycle(input logic rst, input logic [2:0] cs, input logic brk);
        rst_n        = rst;
        CurrentState = cs;
        brake        = brk;
        @(posedge clk);
        #1;
        modelEdge(rst, cs, brk);
    endtask

    task automatic addRep(input int n, input logic rst, input logic [2:0] cs, input logic brk,
                          input logic [2:0] eL, input logic [2:0] eR, input logic eBad);
        vec_t v;
        v.rst = rst; v.cs = cs; v.brk = brk; v.eL = eL; v.eR = eR; v.eBad = eBad;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Reset held with TURN_LEFT pending, then release
        addRep(3, 0, 3'b010, 0, 3'b000, 3'b000, 0);
        addRep(1, 1, 3'b010, 0, 3'b001, 3'b000, 0);
        addRep(1, 1, 3'b000, 0, 3'b000, 3'b000, 0);
        // Left sweep from IDLE
        addRep(4, 1, 3'b010, 0, 3'b001, 3'b000, 0);
        addRep(4, 1, 3'b010, 0, 3'b011, 3'b000, 0);
        addRep(4, 1, 3'b010, 0, 3'b111, 3'b000, 0);
        addRep(4, 1, 3'b010, 0, 3'b000, 3'b000, 0);
        addRep(1, 1, 3'b010, 0, 3'b001, 3'b000, 0);
        // Hazards
        addRep(4, 1, 3'b001, 0, 3'b111, 3'b111, 0);
        addRep(4, 1, 3'b001, 0, 3'b000, 3'b000, 0);
        addRep(1, 1, 3'b001, 0, 3'b111, 3'b111, 0);
        // Illegal code then back to IDLE
        addRep(2, 1, 3'b101, 0, 3'b000, 3'b000, 1);
        addRep(1, 1, 3'b000, 0, 3'b000, 3'b000, 0);
        // Right sweep, switch to left on the step edge
        addRep(4, 1, 3'b011, 0, 3'b000, 3'b001, 0);
        addRep(4, 1, 3'b011, 0, 3'b000, 3'b011, 0);
        addRep(4, 1, 3'b010, 0, 3'b001, 3'b000, 0);
        addRep(1, 1, 3'b010, 0, 3'b011, 3'b000, 0);
`ifdef TAIL_LIGHT_SEQ_BRAKE_EN
        // Brake during left turn, during hazards, and in IDLE
        addRep(3, 1, 3'b010, 1, 3'b011, 3'b111, 0);
        addRep(4, 1, 3'b010, 1, 3'b111, 3'b111, 0);
        addRep(4, 1, 3'b010, 1, 3'b000, 3'b111, 0);
        addRep(1, 1, 3'b010, 1, 3'b001, 3'b111, 0);
        addRep(4, 1, 3'b001, 1, 3'b111, 3'b111, 0);
        addRep(4, 1, 3'b001, 1, 3'b000, 3'b000, 0);
        addRep(1, 1, 3'b000, 1, 3'b111, 3'b111, 0);
        addRep(1, 1, 3'b000, 0, 3'b000, 3'b000, 0);
`endif

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].cs, vecs[i].brk);
            check($sformatf("dir%0d L", i), L_lamps, vecs[i].eL);
            check($sformatf("dir%0d R", i), R_lamps, vecs[i].eR);
            check($sformatf("dir%0d bad", i), {2'b00, bad_state}, {2'b00, vecs[i].eBad});
        end

        begin
            logic [2:0] cs;
            logic       brk;
            logic       rst;
            cs  = 3'b000;
            brk = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 9) == 0) cs = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 11) == 0) brk = ~brk;
                rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                cycle(rst, cs, brk);
                check("rnd L", L_lamps, mL);
                check("rnd R", R_lamps, mR);
                check("rnd bad", {2'b00, bad_state}, {2'b00, mBad});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Output-side consumer of the turn/hazard state code produced by the next-state logic and held in the state register.
- Drives the six tail lamps: three left (LA..LC), three right (RA..RC).
- Generates the visible sequences: progressive turn sweep, hazard blink, all-off idle.
- Owns the step-rate prescaler and phase counter. Lamp outputs are registered.

Parameters:
- TICK_DIV, 12_500_000, clock cycles per sequence step (4 Hz at 50 MHz); legal range ≥2.
- CNT_W, $clog2(TICK_DIV), prescaler width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- CurrentState  input  3  state code: IDLE=000, HAZARDS=001, TURN_LEFT=010, TURN_RIGHT=011
- L_lamps  output  3  left lamps; bit0=LA (inner), bit2=LC (outer)
- R_lamps  output  3  right lamps; bit0=RA (inner), bit2=RC (outer)
- bad_state  output  1  registered flag: CurrentState held an undefined code (100..111) last cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on rst_n.
- Reset (rst_n=0 at a rising edge): cnt=0, phase=0, state_q=IDLE, L_lamps=000, R_lamps=000, bad_state=0. Reset mid-sequence aborts immediately; no partial pattern survives.
- Input decode: codes 100..111 are decoded as IDLE (lamps off); bad_state=1 while such a code is present, with 1-cycle latency.
- Change detect: state_q registers the decoded state each cycle.
  - If decoded CurrentState ≠ state_q: cnt←0, phase←0, lamps←pattern(new state, phase 0).
  - A new state is therefore visible on the lamps 1 cycle after it appears.
- Prescaler: cnt counts 0..TICK_DIV-1, then wraps to 0. step=1 when cnt==TICK_DIV-1.
- Phase: 2-bit counter. On step, phase←phase+1 and wraps 3→0.
- Simultaneous state change and step: the state change wins (phase←0, cnt←0).
- Lamp register: updated every cycle from pattern(state_q_next, phase_next).
- Patterns by phase 0/1/2/3:
  - IDLE: L=000, R=000 for all phases.
  - TURN_LEFT: L=001, 011, 111, 000; R=000.
  - TURN_RIGHT: R=001, 011, 111, 000; L=000.
  - HAZARDS: even phase L=R=111; odd phase L=R=000.
- Full turn cycle = 4·TICK_DIV clocks; hazard period = 2·TICK_DIV clocks.
- No glitches: both lamp vectors come straight from flops.

Optional Feature:
- Macro: TAIL_LIGHT_SEQ_BRAKE_EN.
- Defined:
  - Adds input port brake (1 bit, level).
  - IDLE+brake: L=R=111.
  - TURN_LEFT+brake: R=111, L keeps sequencing.
  - TURN_RIGHT+brake: L=111, R keeps sequencing.
  - HAZARDS: brake ignored.
  - Brake does not reset cnt or phase. Brake effect appears 1 cycle after the input changes.
- Undefined: no brake port; behaviour exactly as above.

Decomposition:
- Package tail_light_pkg holds:
  - state code localparams IDLE/HAZARDS/TURN_LEFT/TURN_RIGHT, shared with the next-state logic;
  - the 4-entry turn sweep pattern constant;
  - LAMPS_ON=3'b111 and LAMPS_OFF=3'b000.
- One sub-module: tick_gen. It holds the TICK_DIV prescaler, has a sync clear input, and outputs the step pulse.
- Pattern selection and the phase counter stay in tail_light_seq.

Test Plan (TICK_DIV=4):
- Reset: hold rst_n=0 for 3 clocks with CurrentState=010 → L=000, R=000, bad_state=0. Release rst_n → L=001 one cycle later.
- Left sweep: CurrentState=010 from IDLE → L=001 at +1 clk, then 011 at +5, 111 at +9, 000 at +13, 001 at +17; R=000 throughout.
- Hazards: CurrentState=001 → L=R=111 at +1, 000 at +5, 111 at +9.
- Mid-sequence switch: in TURN_RIGHT with R=011, drive 010 on the same cycle step fires → next edge R=000, L=001, and the next step comes 4 clocks later.
- Illegal code: CurrentState=101 for 2 cycles → lamps 000, bad_state=1 for those 2 cycles (1-cycle delayed). Return to 000 → bad_state=0.
- Brake (macro on): TURN_LEFT with brake=1 → R=111 constant, L sweeps 001/011/111/000. In HAZARDS with brake=1 → lamps unchanged from the blink pattern.
